// File: rtl/conversor_saida_pkg.sv
// Shared definitions for the output converter: FSM encoding, conversion
// sizing and the seven-segment patterns (stored lit=1, bit 0 = segment a).
package conversor_saida_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    localparam int CICLOS_CONV = 14;
    localparam int NUM_DIGITOS = 4;
    localparam int LARG_MAG    = 14;
    localparam int LARG_BCD    = 4 * NUM_DIGITOS;

    typedef logic [0:6] segmentos_t;

    localparam segmentos_t SEG_0  = 7'b1111110;
    localparam segmentos_t SEG_1  = 7'b0110000;
    localparam segmentos_t SEG_2  = 7'b1101101;
    localparam segmentos_t SEG_3  = 7'b1111001;
    localparam segmentos_t SEG_4  = 7'b0110011;
    localparam segmentos_t SEG_5  = 7'b1011011;
    localparam segmentos_t SEG_6  = 7'b1011111;
    localparam segmentos_t SEG_7  = 7'b1110000;
    localparam segmentos_t SEG_8  = 7'b1111111;
    localparam segmentos_t SEG_9  = 7'b1111011;
    localparam segmentos_t BLANCO = 7'b0000000;
    localparam segmentos_t MENOS  = 7'b0000001;

    // Digit to lit-segment pattern; codes above 9 show nothing.
    function automatic segmentos_t seg_digito(input logic [3:0] digito);
        case (digito)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return BLANCO;
        endcase
    endfunction

    // Converts a lit=1 pattern to the physical drive level of the display.
    function automatic segmentos_t aplica_polaridade(input segmentos_t seg, input bit ativo_baixo);
        return ativo_baixo ? ~seg : seg;
    endfunction

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next magnitude bit.
    function automatic logic [LARG_BCD-1:0] passo_bcd(input logic [LARG_BCD-1:0] bcd,
                                                     input logic bit_entrada);
        logic [LARG_BCD-1:0] ajustado;
        ajustado = bcd;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                ajustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return (ajustado << 1) | {{(LARG_BCD-1){1'b0}}, bit_entrada};
    endfunction

endpackage

// File: rtl/conversor_saida_decodificador.sv
// Combinational seven-segment decoder for one display position.
// Minus has priority over blank, blank over the digit value.
module decodificador_7seg #(
    parameter bit ATIVO_BAIXO = 1'b1
) (
    input  logic [3:0] digito,
    input  logic       apagado,
    input  logic       menos,
    output logic [0:6] segmentos
);
    import conversor_saida_pkg::*;

    segmentos_t logico;

    // Pick the lit pattern, then apply the display polarity.
    always_comb begin
        logico = seg_digito(digito);
        if (apagado)
            logico = BLANCO;
        if (menos)
            logico = MENOS;
        segmentos = aplica_polaridade(logico, ATIVO_BAIXO);
    end

endmodule

// File: rtl/conversor_saida.sv
// Converts a signed register-bank value into four seven-segment digits using a
// serial double-dabble conversion, with a one-deep pending slot for values
// strobed while a conversion is running.
module conversor_saida #(
    parameter int LARGURA     = 32,
    parameter bit ATIVO_BAIXO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    input  logic               carrega,
    output logic [0:6]         saida4,
    output logic [0:6]         saida3,
    output logic [0:6]         saida2,
    output logic [0:6]         saida1,
    output logic               ocupado,
    output logic               erro
);
    import conversor_saida_pkg::*;

    localparam logic [LARGURA-1:0] LIMITE_POS     = LARGURA'(9999);
    localparam logic [LARGURA-1:0] LIMITE_NEG_MAG = LARGURA'(999);
    localparam logic [3:0]         ULTIMO_PASSO   = 4'(CICLOS_CONV - 1);
    localparam segmentos_t         SEG_APAGADO    = aplica_polaridade(BLANCO, ATIVO_BAIXO);
    localparam segmentos_t         SEG_ZERO       = aplica_polaridade(seg_digito(4'd0), ATIVO_BAIXO);

    estado_t               estado, estado_n;
    logic [3:0]            contador, contador_n;
    logic [LARG_MAG-1:0]   magnitude, magnitude_n;
    logic [LARG_BCD-1:0]   bcd, bcd_n;
    logic                  negativo, negativo_n;
    logic                  erro_conv, erro_conv_n;
    logic                  pend_valido, pend_valido_n;
    logic [LARGURA-1:0]    pend_valor, pend_valor_n;
    logic                  ocupado_n, erro_n;
    segmentos_t            saida4_n, saida3_n, saida2_n, saida1_n;

    logic [LARGURA-1:0]    valor_sel, valor_abs;
    logic                  sinal_sel, estouro_sel, captura;
    logic [NUM_DIGITOS-1:0] apaga, menos;
    segmentos_t            seg_dec [NUM_DIGITOS];

    // Value to capture: ATUALIZA without a fresh strobe takes the pending slot.
    // Overflow compares the full-width magnitude so the most negative input is caught too.
    always_comb begin
        valor_sel   = (estado == ATUALIZA && !carrega) ? pend_valor : entrada;
        sinal_sel   = valor_sel[LARGURA-1];
        valor_abs   = sinal_sel ? (~valor_sel + LARGURA'(1)) : valor_sel;
        estouro_sel = sinal_sel ? (valor_abs > LIMITE_NEG_MAG) : (valor_abs > LIMITE_POS);
        captura     = (estado == OCIOSO && carrega) ||
                      (estado == ATUALIZA && (carrega || pend_valido));
    end

    // Blanking and minus selects derived from the finished BCD result.
    // Negative values never exceed three digits, so digit positions match the positive case.
    always_comb begin
        apaga = '0;
        menos = '0;
        if (erro_conv) begin
            menos = '1;
        end else if (negativo) begin
            menos[3] = 1'b1;
            apaga[2] = (bcd[11:8] == 4'd0);
            apaga[1] = apaga[2] && (bcd[7:4] == 4'd0);
        end else begin
            apaga[3] = (bcd[15:12] == 4'd0);
            apaga[2] = apaga[3] && (bcd[11:8] == 4'd0);
            apaga[1] = apaga[2] && (bcd[7:4] == 4'd0);
        end
    end

    for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_dec
        decodificador_7seg #(
            .ATIVO_BAIXO(ATIVO_BAIXO)
        ) u_dec (
            .digito   (bcd[4*i +: 4]),
            .apagado  (apaga[i]),
            .menos    (menos[i]),
            .segmentos(seg_dec[i])
        );
    end

    // Next-state and datapath updates for the three-state conversion FSM.
    always_comb begin
        estado_n      = estado;
        contador_n    = contador;
        magnitude_n   = magnitude;
        bcd_n         = bcd;
        negativo_n    = negativo;
        erro_conv_n   = erro_conv;
        pend_valido_n = pend_valido;
        pend_valor_n  = pend_valor;
        ocupado_n     = ocupado;
        erro_n        = erro;
        saida4_n      = saida4;
        saida3_n      = saida3;
        saida2_n      = saida2;
        saida1_n      = saida1;

        case (estado)
            OCIOSO: begin
                if (carrega)
                    estado_n = CONVERTE;
            end
            CONVERTE: begin
                bcd_n       = passo_bcd(bcd, magnitude[LARG_MAG-1]);
                magnitude_n = magnitude << 1;
                contador_n  = contador + 4'd1;
                if (contador == ULTIMO_PASSO)
                    estado_n = ATUALIZA;
                if (carrega) begin
                    pend_valor_n  = entrada;
                    pend_valido_n = 1'b1;
                end
            end
            ATUALIZA: begin
                saida4_n  = seg_dec[3];
                saida3_n  = seg_dec[2];
                saida2_n  = seg_dec[1];
                saida1_n  = seg_dec[0];
                erro_n    = erro_conv;
                ocupado_n = 1'b0;
                estado_n  = OCIOSO;
                if (carrega || pend_valido) begin
                    // A fresh strobe is newer than anything pending, so the slot is dropped either way.
                    pend_valido_n = 1'b0;
                    estado_n      = CONVERTE;
                end
            end
            default: estado_n = OCIOSO;
        endcase

        if (captura) begin
            magnitude_n = valor_abs[LARG_MAG-1:0];
            bcd_n       = '0;
            negativo_n  = sinal_sel;
            erro_conv_n = estouro_sel;
            contador_n  = '0;
            ocupado_n   = 1'b1;
        end
    end

    // State register; reset discards any conversion and pending value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            contador    <= '0;
            magnitude   <= '0;
            bcd         <= '0;
            negativo    <= 1'b0;
            erro_conv   <= 1'b0;
            pend_valido <= 1'b0;
            pend_valor  <= '0;
            ocupado     <= 1'b0;
            erro        <= 1'b0;
            saida4      <= SEG_APAGADO;
            saida3      <= SEG_APAGADO;
            saida2      <= SEG_APAGADO;
            saida1      <= SEG_ZERO;
        end else begin
            estado      <= estado_n;
            contador    <= contador_n;
            magnitude   <= magnitude_n;
            bcd         <= bcd_n;
            negativo    <= negativo_n;
            erro_conv   <= erro_conv_n;
            pend_valido <= pend_valido_n;
            pend_valor  <= pend_valor_n;
            ocupado     <= ocupado_n;
            erro        <= erro_n;
            saida4      <= saida4_n;
            saida3      <= saida3_n;
            saida2      <= saida2_n;
            saida1      <= saida1_n;
        end
    end

endmodule

// File: tb/tb_conversor_saida.sv
// Self-checking bench for conversor_saida with active-low segments.
module tb_conversor_saida;

    logic        clk = 1'b0;
    logic        reset;
    logic        carrega;
    logic [31:0] entrada;
    logic [0:6]  saida4, saida3, saida2, saida1;
    logic        ocupado, erro;

    int checks = 0;
    int errors = 0;

    localparam logic [0:6] APG = 7'b1111111;
    localparam logic [0:6] MEN = 7'b1111110;
    localparam logic [0:6] D0  = 7'b0000001;
    localparam logic [0:6] D1  = 7'b1001111;
    localparam logic [0:6] D2  = 7'b0010010;
    localparam logic [0:6] D3  = 7'b0000110;
    localparam logic [0:6] D4  = 7'b1001100;
    localparam logic [0:6] D5  = 7'b0100100;
    localparam logic [0:6] D7  = 7'b0001111;
    localparam logic [0:6] D9  = 7'b0000100;

    typedef struct {
        logic [31:0] valor;
        logic [0:6]  s4, s3, s2, s1;
        logic        erro;
    } vetor_t;

    vetor_t tabela [10];
    vetor_t fila [$];

    always #5 clk = ~clk;

    conversor_saida #(
        .LARGURA    (32),
        .ATIVO_BAIXO(1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .entrada(entrada),
        .carrega(carrega),
        .saida4 (saida4),
        .saida3 (saida3),
        .saida2 (saida2),
        .saida1 (saida1),
        .ocupado(ocupado),
        .erro   (erro)
    );

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", nome, atual, esperado);
        end
    endtask

    task automatic checkDisplay(input string nome, input vetor_t e);
        checkOutput({nome, ".s4"}, 32'(saida4), 32'(e.s4));
        checkOutput({nome, ".s3"}, 32'(saida3), 32'(e.s3));
        checkOutput({nome, ".s2"}, 32'(saida2), 32'(e.s2));
        checkOutput({nome, ".s1"}, 32'(saida1), 32'(e.s1));
        checkOutput({nome, ".erro"}, 32'(erro), 32'(e.erro));
    endtask

    // One-cycle strobe; returns at the falling edge right after the capturing edge.
    task automatic applyStimulus(input logic [31:0] v);
        @(negedge clk);
        entrada = v;
        carrega = 1'b1;
        @(negedge clk);
        carrega = 1'b0;
    endtask

    task automatic runVector(input string nome, input vetor_t v);
        vetor_t e;
        int n;
        fila.push_back(v);
        applyStimulus(v.valor);
        n = 0;
        while (ocupado && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput({nome, ".latency"}, 32'(n), 32'd15);
        e = fila.pop_front();
        checkDisplay(nome, e);
    endtask

    initial begin
        vetor_t e;
        bit viu_ocupado;

        tabela[0] = '{32'd1234,       D1,  D2,  D3,  D4,  1'b0};
        tabela[1] = '{32'hFFFFFFC7,   MEN, APG, D5,  D7,  1'b0};
        tabela[2] = '{32'd7,          APG, APG, APG, D7,  1'b0};
        tabela[3] = '{32'd0,          APG, APG, APG, D0,  1'b0};
        tabela[4] = '{32'd10000,      MEN, MEN, MEN, MEN, 1'b1};
        tabela[5] = '{32'hFFFFFC18,   MEN, MEN, MEN, MEN, 1'b1};
        tabela[6] = '{32'd9999,       D9,  D9,  D9,  D9,  1'b0};
        tabela[7] = '{32'hFFFFFC19,   MEN, D9,  D9,  D9,  1'b0};
        tabela[8] = '{32'd100,        APG, D1,  D0,  D0,  1'b0};
        tabela[9] = '{32'hFFFFFFFB,   MEN, APG, APG, D5,  1'b0};

        reset   = 1'b1;
        carrega = 1'b0;
        entrada = '0;
        #2;
        checkDisplay("reset", '{32'd0, APG, APG, APG, D0, 1'b0});
        checkOutput("reset.ocupado", 32'(ocupado), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            runVector($sformatf("vec%0d", i), tabela[i]);

        // 1234 followed by 42 and 99 strobed mid-conversion: only 1234 and 99 appear.
        fila.push_back(tabela[0]);
        fila.push_back('{32'd99, APG, APG, D9, D9, 1'b0});
        @(negedge clk);
        entrada = 32'd1234;
        carrega = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            carrega = (i == 2 || i == 5);
            entrada = (i == 2) ? 32'd42 : 32'd99;
            if (i == 15) begin
                checkOutput("pend.busy_e15", 32'(ocupado), 32'd1);
                e = fila.pop_front();
                checkDisplay("pend.first", e);
            end
            if (i == 22)
                checkOutput("pend.hold", 32'(saida1), 32'(D4));
            if (i == 30) begin
                checkOutput("pend.idle_e30", 32'(ocupado), 32'd0);
                e = fila.pop_front();
                checkDisplay("pend.second", e);
            end
        end

        // Leave an overflow on display so reset has something to clear.
        runVector("pre_reset", tabela[4]);

        // Reset during a conversion with a value pending.
        applyStimulus(32'd1234);
        repeat (2) @(negedge clk);
        entrada = 32'd77;
        carrega = 1'b1;
        @(negedge clk);
        carrega = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkDisplay("midreset", '{32'd0, APG, APG, APG, D0, 1'b0});
        checkOutput("midreset.ocupado", 32'(ocupado), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        viu_ocupado = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ocupado)
                viu_ocupado = 1'b1;
        end
        checkOutput("postreset.no_start", 32'(viu_ocupado), 32'd0);
        checkDisplay("postreset", '{32'd0, APG, APG, APG, D0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conversor_saida.md
CONVERSOR_SAIDA -- requirements
Module: conversor_saida

Interface
REQ-001 Parameter: LARGURA, default 32, data input width in bits.
REQ-002 Parameter: ATIVO_BAIXO, default 1, segment polarity (1 = segment lit when driven 0).
REQ-003 Port: clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: entrada  input  LARGURA  signed two's-complement value from the register bank output port.
REQ-006 Port: carrega  input  1  load strobe, driven by the controller's output-enable; sampled on every rising edge.
REQ-007 Port: saida4..saida1  output  [0:6] each  seven-segment drives, bit 0 = segment a through bit 6 = segment g; saida4 is leftmost, saida1 is units.
REQ-008 Port: ocupado  output  1  high while a conversion is in progress.
REQ-009 Port: erro  output  1  registered overflow flag for the value currently displayed.

Function
REQ-010 The FSM SHALL have exactly three states: OCIOSO, CONVERTE and ATUALIZA.
REQ-011 In OCIOSO, carrega=1 at edge E0 SHALL capture entrada, compute its sign and magnitude, set ocupado=1, clear the step counter and enter CONVERTE.
REQ-012 CONVERTE SHALL perform one double-dabble step per edge, E1..E14: add 3 to every BCD nibble >=5, then shift the magnitude left by one bit into the BCD register.
REQ-013 The magnitude register SHALL be 14 bits wide and the BCD register 16 bits (4 nibbles).
REQ-014 At E14 the FSM SHALL enter ATUALIZA.
REQ-015 At E15 the display registers and erro SHALL load, and ocupado SHALL drop; end-to-end latency from the capturing edge to visible output is exactly 15 cycles.
REQ-016 Overflow is defined as value >9999 or value < -999; it SHALL be detected at capture.
REQ-017 When erro=1, all four displays SHALL show minus (g only).
REQ-018 A negative value SHALL drive saida4 to minus; saida3..saida1 then show up to 3 magnitude digits.
REQ-019 Leading-zero blanking: every zero digit left of the most significant non-zero digit SHALL be blank, and saida1 SHALL never be blank (0 displays as "0").
REQ-020 carrega=1 while not in OCIOSO SHALL write entrada into a one-deep pending register and set pending-valid; a later strobe overwrites it (last value wins).
REQ-021 In ATUALIZA: if carrega=1, entrada SHALL be captured directly; else if pending-valid, the pending value SHALL be captured and pending-valid cleared; in either case the FSM re-enters CONVERTE and ocupado stays high.
REQ-022 Display registers SHALL change only in ATUALIZA; they are stable during conversion.
REQ-023 Segment polarity SHALL follow ATIVO_BAIXO: blank = all segments off, minus = only g on.

Reset
REQ-024 Asserting reset SHALL immediately force OCIOSO, ocupado=0, erro=0, pending-valid=0, counter=0, saida4..saida2 blank and saida1 "0".
REQ-025 Reset asserted mid-conversion SHALL discard both the conversion and any pending value.
REQ-026 After reset deassertion, no conversion SHALL start without a new carrega.

Structure
REQ-027 A shared package SHALL hold the state encoding, CICLOS_CONV=14, the BCD digit count 4, and segment constants (digits 0-9, BLANCO, MENOS).
REQ-028 A single combinational sub-module, decodificador_7seg (4-bit digit + blank + minus selects -> 7 segments), SHALL be instantiated once per display.

Verification (ATIVO_BAIXO=1)
REQ-029 reset, then 1234 with a one-cycle carrega -> ocupado high for 15 cycles, then saida4..1 = 1001111, 0010010, 0000110, 1001100; erro=0.
REQ-030 32'hFFFFFFC7 (-57) -> saida4 = 1111110, saida3 = 1111111, saida2 = 0100100, saida1 = 0001111.
REQ-031 7 -> saida4..2 blank, saida1 = 0001111; 0 -> saida1 = 0000001, others blank.
REQ-032 10000 and -1000 -> erro=1 and all displays 1111110; then 9999 -> erro=0 and 9999 displayed.
REQ-033 1234 loaded, then 42 and 99 strobed during CONVERTE -> 1234 shown at E15, second conversion starts without an OCIOSO cycle, 99 shown 15 cycles later, 42 never displayed.
REQ-034 reset pulsed at E7 of a conversion while a value is pending -> reset outputs immediately, and no display update follows without a new carrega.
